// File: rtl/fetch_queue.sv
// Dual-issue fetch/decode instruction buffer: circular store of {instr, pc},
// show-ahead read of the two oldest entries, stall and flush handling.

module fq_lane #(
    parameter int WIDTH = 32
) (
    input  logic             valid,
    input  logic [WIDTH-1:0] instr_in,
    input  logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] pc_out
);
    // Invalid lanes read as zero so decode never sees stale storage.
    assign instr_out = valid ? instr_in : '0;
    assign pc_out    = valid ? pc_in    : '0;
endmodule

module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flushd,
    input  logic [1:0]                 enq_valid,
    input  logic [WIDTH-1:0]           instrf,
    input  logic [WIDTH-1:0]           instrf2,
    input  logic [WIDTH-1:0]           pcf,
    input  logic [1:0]                 deq_cnt,
    output logic [WIDTH-1:0]           instrd,
    output logic [WIDTH-1:0]           instrd2,
    output logic [WIDTH-1:0]           pcd,
    output logic [WIDTH-1:0]           pcd2,
    output logic [1:0]                 validd,
    output logic                       stallf,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int NUM_LANES = 2;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc;
    } entry_t;

    entry_t mem [DEPTH];

    logic [AW-1:0] head, tail;
    logic [CW-1:0] count_q;
    logic [1:0]    deq_req, deq_n, enq_n;

    logic [NUM_LANES-1:0]            lane_vld;
    logic [NUM_LANES-1:0][WIDTH-1:0] lane_instr, lane_pc;

    // Stall looks only at registered occupancy, keeping deq_cnt off the fetch path.
    assign stallf = (count_q > CW'(DEPTH - 2));

    always_comb begin
        deq_req = (deq_cnt == 2'd3) ? 2'd2 : deq_cnt;
        deq_n   = (CW'(deq_req) > count_q) ? count_q[1:0] : deq_req;
        enq_n   = 2'd0;
        if (!stallf && !flushd) begin
            if (enq_valid == 2'b01)      enq_n = 2'd1;
            else if (enq_valid == 2'b11) enq_n = 2'd2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flushd) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + AW'(deq_n);
            tail    <= tail + AW'(enq_n);
            count_q <= count_q + CW'(enq_n) - CW'(deq_n);
        end
    end

    always_ff @(posedge clk) begin
        if (enq_n != 2'd0)
            mem[tail] <= '{instr: instrf, pc: pcf};
        if (enq_n == 2'd2)
            mem[tail + AW'(1)] <= '{instr: instrf2, pc: pcf + WIDTH'(4)};
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [AW-1:0] rd_idx;
        entry_t        rd_ent;
        assign rd_idx      = head + AW'(i);
        assign rd_ent      = mem[rd_idx];
        assign lane_vld[i] = (count_q > CW'(i));
        fq_lane #(.WIDTH(WIDTH)) u_lane (
            .valid    (lane_vld[i]),
            .instr_in (rd_ent.instr),
            .pc_in    (rd_ent.pc),
            .instr_out(lane_instr[i]),
            .pc_out   (lane_pc[i])
        );
    end

    assign validd  = lane_vld;
    assign instrd  = lane_instr[0];
    assign instrd2 = lane_instr[1];
    assign pcd     = lane_pc[0];
    assign pcd2    = lane_pc[1];
    assign count   = count_q;
endmodule
